// File: rtl/pattern_lut_arbiter.sv
// pattern_lut_arbiter
//   Shares the two read lanes of the ccLUT pattern lookup among NREQ
//   pattern-finder requesters and one VME debug readback port.
//   Up to two functional lookups are granted per cycle in round-robin order.
//   Lane 0 is functional only. Lane 1 is functional, or carries the pending
//   VME read when at most one functional grant is possible, or when that
//   read has starved for MAX_STARVE cycles. Each lookup is tagged through
//   the LUT latency, and its result is returned to the requester that issued
//   it. The fixed grant-to-response latency is LUT_LAT+2 cycles.
// Ports:
//   clock, global_reset          : clock, synchronous active-high reset
//   req_valid/req_ready          : per-requester handshake (ready is combinational)
//   req_pat/req_carry            : per-requester packed pattern word / carry address
//   lut_pat0/1, lut_carry0/1     : registered LUT inputs, lane 0 / lane 1
//   lut_offs/bend/quality0/1     : LUT outputs, valid LUT_LAT cycles after the inputs
//   rsp_valid/offs/bend/quality  : per-requester response strobe and held data
//   vme_rd_req/pat/carry         : readback request (sampled in IDLE only)
//   vme_rd_busy/done/data        : readback status, strobe and held {offs,bend,quality}
module pattern_lut_arbiter #(
  parameter int NREQ       = 4,
  parameter int MXPATB     = 7,
  parameter int MXPATC     = 12,
  parameter int LUT_LAT    = 1,
  parameter int MAX_STARVE = 15
) (
  input  logic                   clock,
  input  logic                   global_reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*MXPATB-1:0] req_pat,
  input  logic [NREQ*MXPATC-1:0] req_carry,
  output logic [MXPATB-1:0]      lut_pat0,
  output logic [MXPATB-1:0]      lut_pat1,
  output logic [MXPATC-1:0]      lut_carry0,
  output logic [MXPATC-1:0]      lut_carry1,
  input  logic [3:0]             lut_offs0,
  input  logic [3:0]             lut_offs1,
  input  logic [4:0]             lut_bend0,
  input  logic [4:0]             lut_bend1,
  input  logic [8:0]             lut_quality0,
  input  logic [8:0]             lut_quality1,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ*4-1:0]      rsp_offs,
  output logic [NREQ*5-1:0]      rsp_bend,
  output logic [NREQ*9-1:0]      rsp_quality,
  input  logic                   vme_rd_req,
  input  logic [MXPATB-1:0]      vme_rd_pat,
  input  logic [MXPATC-1:0]      vme_rd_carry,
  output logic                   vme_rd_busy,
  output logic                   vme_rd_done,
  output logic [17:0]            vme_rd_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [PW:0]   NREQ_W     = (PW+1)'(NREQ);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, WAIT_DATA, DONE} vme_state_e;

  // Unpacked views of the packed per-requester buses
  logic [MXPATB-1:0] pat_arr   [NREQ];
  logic [MXPATC-1:0] carry_arr [NREQ];

  // State
  logic [PW-1:0]     ptr_q, ptr_d;
  vme_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [MXPATB-1:0] vme_pat_q, vme_pat_d;
  logic [MXPATC-1:0] vme_carry_q, vme_carry_d;
  logic [MXPATB-1:0] lut_pat0_q, lut_pat0_d, lut_pat1_q, lut_pat1_d;
  logic [MXPATC-1:0] lut_carry0_q, lut_carry0_d, lut_carry1_q, lut_carry1_d;
  // Lane tags: lane 0 = {valid, owner}; lane 1 = {valid, owner, is_vme}
  logic [PW:0]       tag0_q [LUT_LAT+1];
  logic [PW:0]       tag0_d [LUT_LAT+1];
  logic [PW+1:0]     tag1_q [LUT_LAT+1];
  logic [PW+1:0]     tag1_d [LUT_LAT+1];
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [3:0]        rsp_offs_q [NREQ];
  logic [3:0]        rsp_offs_d [NREQ];
  logic [4:0]        rsp_bend_q [NREQ];
  logic [4:0]        rsp_bend_d [NREQ];
  logic [8:0]        rsp_quality_q [NREQ];
  logic [8:0]        rsp_quality_d [NREQ];
  logic [17:0]       vme_rd_data_q, vme_rd_data_d;
  logic              vme_rd_done_q, vme_rd_done_d;

  // Arbitration results
  logic          first_v, second_v, grant1, vme_take;
  logic [PW-1:0] first_idx, second_idx;
  logic [PW:0]   t0;
  logic [PW+1:0] t1;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign pat_arr[gi]                 = req_pat[gi*MXPATB +: MXPATB];
      assign carry_arr[gi]               = req_carry[gi*MXPATC +: MXPATC];
      assign rsp_offs[gi*4 +: 4]         = rsp_offs_q[gi];
      assign rsp_bend[gi*5 +: 5]         = rsp_bend_q[gi];
      assign rsp_quality[gi*9 +: 9]      = rsp_quality_q[gi];
    end
  endgenerate

  // Round-robin scan from the pointer. The first two valid requesters are candidates
  // for lane 0 and lane 1. A VME read in WAIT_SLOT takes lane 1 when no second
  // candidate exists, or unconditionally once starved.
  always_comb begin : arb
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [PW-1:0] last;
    logic [PW:0]   nxt;
    first_v    = 1'b0;
    second_v   = 1'b0;
    first_idx  = '0;
    second_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[PW-1:0];
      if (req_valid[idx]) begin
        if (!first_v) begin
          first_v   = 1'b1;
          first_idx = idx;
        end else if (!second_v) begin
          second_v   = 1'b1;
          second_idx = idx;
        end
      end
    end
    vme_take  = (state_q == WAIT_SLOT) && (!second_v || (starve_q == STARVE_MAX));
    grant1    = second_v && !vme_take;
    req_ready = '0;
    if (first_v) req_ready[first_idx]  = 1'b1;
    if (grant1)  req_ready[second_idx] = 1'b1;
    last = grant1 ? second_idx : first_idx;
    nxt  = {1'b0, last} + (PW+1)'(1);
    if (nxt >= NREQ_W) nxt = '0;
    ptr_d = first_v ? nxt[PW-1:0] : ptr_q;
  end

  // Lane input registers and tag delay lines
  always_comb begin
    lut_pat0_d   = first_v ? pat_arr[first_idx]   : '0;
    lut_carry0_d = first_v ? carry_arr[first_idx] : '0;
    if (vme_take) begin
      lut_pat1_d   = vme_pat_q;
      lut_carry1_d = vme_carry_q;
    end else begin
      lut_pat1_d   = grant1 ? pat_arr[second_idx]   : '0;
      lut_carry1_d = grant1 ? carry_arr[second_idx] : '0;
    end
    tag0_d[0] = {first_v, first_idx};
    tag1_d[0] = {grant1 | vme_take, vme_take ? '0 : second_idx, vme_take};
    for (int k = 1; k <= LUT_LAT; k++) begin
      tag0_d[k] = tag0_q[k-1];
      tag1_d[k] = tag1_q[k-1];
    end
  end

  // Tags leaving the delay line line up with the LUT outputs of their lane
  assign t0 = tag0_q[LUT_LAT];
  assign t1 = tag1_q[LUT_LAT];

  always_comb begin
    rsp_valid_d   = '0;
    rsp_offs_d    = rsp_offs_q;
    rsp_bend_d    = rsp_bend_q;
    rsp_quality_d = rsp_quality_q;
    vme_rd_data_d = vme_rd_data_q;
    vme_rd_done_d = 1'b0;
    if (t0[PW]) begin
      rsp_valid_d[t0[PW-1:0]]   = 1'b1;
      rsp_offs_d[t0[PW-1:0]]    = lut_offs0;
      rsp_bend_d[t0[PW-1:0]]    = lut_bend0;
      rsp_quality_d[t0[PW-1:0]] = lut_quality0;
    end
    if (t1[PW+1]) begin
      if (t1[0]) begin
        vme_rd_data_d = {lut_offs1, lut_bend1, lut_quality1};
        vme_rd_done_d = 1'b1;
      end else begin
        rsp_valid_d[t1[PW:1]]   = 1'b1;
        rsp_offs_d[t1[PW:1]]    = lut_offs1;
        rsp_bend_d[t1[PW:1]]    = lut_bend1;
        rsp_quality_d[t1[PW:1]] = lut_quality1;
      end
    end
  end

  // VME readback sequencing. WAIT_DATA is left once the registered done strobe
  // is visible, so DONE always follows the pulse by one cycle.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    vme_pat_d   = vme_pat_q;
    vme_carry_d = vme_carry_q;
    case (state_q)
      IDLE: if (vme_rd_req) begin
        vme_pat_d   = vme_rd_pat;
        vme_carry_d = vme_rd_carry;
        starve_d    = '0;
        state_d     = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (vme_take) state_d = WAIT_DATA;
        else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
      end
      WAIT_DATA: if (vme_rd_done_q) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      ptr_q         <= '0;
      state_q       <= IDLE;
      starve_q      <= '0;
      vme_pat_q     <= '0;
      vme_carry_q   <= '0;
      lut_pat0_q    <= '0;
      lut_pat1_q    <= '0;
      lut_carry0_q  <= '0;
      lut_carry1_q  <= '0;
      rsp_valid_q   <= '0;
      vme_rd_data_q <= '0;
      vme_rd_done_q <= 1'b0;
      for (int k = 0; k <= LUT_LAT; k++) begin
        tag0_q[k] <= '0;
        tag1_q[k] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        rsp_offs_q[i]    <= '0;
        rsp_bend_q[i]    <= '0;
        rsp_quality_q[i] <= '0;
      end
    end else begin
      ptr_q         <= ptr_d;
      state_q       <= state_d;
      starve_q      <= starve_d;
      vme_pat_q     <= vme_pat_d;
      vme_carry_q   <= vme_carry_d;
      lut_pat0_q    <= lut_pat0_d;
      lut_pat1_q    <= lut_pat1_d;
      lut_carry0_q  <= lut_carry0_d;
      lut_carry1_q  <= lut_carry1_d;
      rsp_valid_q   <= rsp_valid_d;
      vme_rd_data_q <= vme_rd_data_d;
      vme_rd_done_q <= vme_rd_done_d;
      tag0_q        <= tag0_d;
      tag1_q        <= tag1_d;
      rsp_offs_q    <= rsp_offs_d;
      rsp_bend_q    <= rsp_bend_d;
      rsp_quality_q <= rsp_quality_d;
    end
  end

  assign lut_pat0    = lut_pat0_q;
  assign lut_pat1    = lut_pat1_q;
  assign lut_carry0  = lut_carry0_q;
  assign lut_carry1  = lut_carry1_q;
  assign rsp_valid   = rsp_valid_q;
  assign vme_rd_busy = (state_q != IDLE);
  assign vme_rd_done = vme_rd_done_q;
  assign vme_rd_data = vme_rd_data_q;

endmodule

// File: tb/tb_pattern_lut_arbiter.sv
// Directed testbench for pattern_lut_arbiter with a one-cycle registered LUT model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_pattern_lut_arbiter;

  logic        clock = 1'b0;
  logic        global_reset;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [27:0] req_pat;
  logic [47:0] req_carry;
  logic [6:0]  lut_pat0, lut_pat1, vme_rd_pat;
  logic [11:0] lut_carry0, lut_carry1, vme_rd_carry;
  logic [3:0]  lut_offs0, lut_offs1;
  logic [4:0]  lut_bend0, lut_bend1;
  logic [8:0]  lut_quality0, lut_quality1;
  logic [15:0] rsp_offs;
  logic [19:0] rsp_bend;
  logic [35:0] rsp_quality;
  logic        vme_rd_req, vme_rd_busy, vme_rd_done;
  logic [17:0] vme_rd_data;
  logic [17:0] lut0_q, lut1_q;
  logic [133:0] outs;

  int checks = 0;
  int errors = 0;

  logic [6:0]  pat_tab   [4] = '{7'h11, 7'h22, 7'h53, 7'h6E};
  logic [11:0] carry_tab [4] = '{12'h1A5, 12'h2B6, 12'h3C7, 12'h4D8};

  always #5 clock = ~clock;

  pattern_lut_arbiter dut (
    .clock(clock), .global_reset(global_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pat(req_pat), .req_carry(req_carry),
    .lut_pat0(lut_pat0), .lut_pat1(lut_pat1),
    .lut_carry0(lut_carry0), .lut_carry1(lut_carry1),
    .lut_offs0(lut_offs0), .lut_offs1(lut_offs1),
    .lut_bend0(lut_bend0), .lut_bend1(lut_bend1),
    .lut_quality0(lut_quality0), .lut_quality1(lut_quality1),
    .rsp_valid(rsp_valid), .rsp_offs(rsp_offs), .rsp_bend(rsp_bend), .rsp_quality(rsp_quality),
    .vme_rd_req(vme_rd_req), .vme_rd_pat(vme_rd_pat), .vme_rd_carry(vme_rd_carry),
    .vme_rd_busy(vme_rd_busy), .vme_rd_done(vme_rd_done), .vme_rd_data(vme_rd_data)
  );

  // LUT content model: {offs, bend, quality} as a fixed function of pattern and carry
  function automatic logic [17:0] lut_fn(input logic [6:0] p, input logic [11:0] c);
    logic [3:0] o;
    logic [4:0] b;
    logic [8:0] q;
    o = c[3:0];
    b = {1'b0, p[3:0]} - 5'd1;
    q = {p[6], p[4], p[3], p[1], c[8], c[3:0] ^ 4'h3};
    return {o, b, q};
  endfunction

  always @(posedge clock) begin
    lut0_q <= lut_fn(lut_pat0, lut_carry0);
    lut1_q <= lut_fn(lut_pat1, lut_carry1);
  end
  assign {lut_offs0, lut_bend0, lut_quality0} = lut0_q;
  assign {lut_offs1, lut_bend1, lut_quality1} = lut1_q;

  assign outs = {lut_pat0, lut_pat1, lut_carry0, lut_carry1, rsp_valid, rsp_offs, rsp_bend,
                 rsp_quality, vme_rd_busy, vme_rd_done, vme_rd_data};

  function automatic logic [17:0] get_rsp(input int i);
    return {rsp_offs[i*4 +: 4], rsp_bend[i*5 +: 5], rsp_quality[i*9 +: 9]};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic load_tab();
    for (int i = 0; i < 4; i++) begin
      req_pat[i*7 +: 7]    = pat_tab[i];
      req_carry[i*12 +: 12] = carry_tab[i];
    end
  endtask

  task automatic do_reset();
    global_reset = 1'b1;
    req_valid    = '0;
    vme_rd_req   = 1'b0;
    cyc();
    cyc();
    global_reset = 1'b0;
  endtask

  task automatic test_reset();
    vme_rd_pat   = '0;
    vme_rd_carry = '0;
    req_pat      = '0;
    req_carry    = '0;
    do_reset();
    smp();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    req_pat[6:0]    = 7'h5A;
    req_carry[11:0] = 12'h123;
    req_valid       = 4'b0001;
    smp();
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    cyc();
    req_valid = '0;
    smp();
    checks++;
    if ({lut_pat0, lut_carry0} !== {7'h5A, 12'h123}) begin
      errors++; $display("FAIL single_lane0 got %h/%h exp 5a/123", lut_pat0, lut_carry0);
    end
    checks++;
    if ({lut_pat1, lut_carry1} !== '0) begin
      errors++; $display("FAIL single_lane1_idle got %h/%h exp 0/0", lut_pat1, lut_carry1);
    end
    cyc();
    smp();
    checks++;
    if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp got %b exp 0000", rsp_valid); end
    cyc();
    smp();
    checks++;
    if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid); end
    checks++;
    if (get_rsp(0) !== {4'h3, 5'h09, 9'h1F0}) begin
      errors++; $display("FAIL single_rsp_data got %h exp %h", get_rsp(0), {4'h3, 5'h09, 9'h1F0});
    end
    cyc();
    smp();
    checks++;
    if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_pulse got %b exp 0000", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [3:0] rdy_tab [7] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0000, 4'b0000, 4'b0000};
    int l0;
    do_reset();
    load_tab();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) cyc();
      req_valid = (c < 4) ? 4'hF : 4'h0;
      smp();
      checks++;
      if (req_ready !== rdy_tab[c]) begin
        errors++; $display("FAIL cont_ready c%0d got %b exp %b", c, req_ready, rdy_tab[c]);
      end
      if (c >= 1 && c <= 4) begin
        l0 = ((c - 1) % 2 == 0) ? 0 : 2;
        checks++;
        if ({lut_pat0, lut_pat1, lut_carry0, lut_carry1} !==
            {pat_tab[l0], pat_tab[l0+1], carry_tab[l0], carry_tab[l0+1]}) begin
          errors++; $display("FAIL cont_lanes c%0d got %h %h exp %h %h", c, lut_pat0, lut_pat1,
                             pat_tab[l0], pat_tab[l0+1]);
        end
      end
      if (c >= 3) begin
        checks++;
        if (rsp_valid !== rdy_tab[c-3]) begin
          errors++; $display("FAIL cont_rsp_valid c%0d got %b exp %b", c, rsp_valid, rdy_tab[c-3]);
        end
        for (int i = 0; i < 4; i++) begin
          if (rdy_tab[c-3][i]) begin
            checks++;
            if (get_rsp(i) !== lut_fn(pat_tab[i], carry_tab[i])) begin
              errors++; $display("FAIL cont_rsp_data r%0d got %h exp %h", i, get_rsp(i),
                                 lut_fn(pat_tab[i], carry_tab[i]));
            end
          end
        end
      end else begin
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL cont_rsp_early c%0d got %b exp 0000", c, rsp_valid); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_rsp [3] = '{4'b0100, 4'b1001, 4'b0110};
    do_reset();
    load_tab();
    req_valid = 4'b0100;
    smp();
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_setup got %b exp 0100", req_ready); end
    cyc();
    req_valid = 4'b1001;
    smp();
    checks++;
    if (req_ready !== 4'b1001) begin errors++; $display("FAIL wrap_ready got %b exp 1001", req_ready); end
    cyc();
    req_valid = 4'b1111;
    smp();
    checks++;
    if (req_ready !== 4'b0110) begin errors++; $display("FAIL wrap_ptr got %b exp 0110", req_ready); end
    checks++;
    if ({lut_pat0, lut_carry0, lut_pat1, lut_carry1} !== {pat_tab[3], carry_tab[3], pat_tab[0], carry_tab[0]}) begin
      errors++; $display("FAIL wrap_lanes got %h %h exp %h %h", lut_pat0, lut_pat1, pat_tab[3], pat_tab[0]);
    end
    for (int c = 3; c < 7; c++) begin
      cyc();
      req_valid = '0;
      smp();
      checks++;
      if (rsp_valid !== ((c < 6) ? exp_rsp[c-3] : 4'b0000)) begin
        errors++; $display("FAIL wrap_rsp c%0d got %b", c, rsp_valid);
      end
      if (c == 4) begin
        checks++;
        if ({get_rsp(3), get_rsp(0)} !== {lut_fn(pat_tab[3], carry_tab[3]), lut_fn(pat_tab[0], carry_tab[0])}) begin
          errors++; $display("FAIL wrap_rsp_data got %h %h", get_rsp(3), get_rsp(0));
        end
      end
    end
  endtask

  task automatic test_vme_free();
    logic [17:0] vexp;
    vexp = lut_fn(7'h6C, 12'hABC);
    do_reset();
    load_tab();
    vme_rd_pat   = 7'h6C;
    vme_rd_carry = 12'hABC;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) cyc();
      vme_rd_req = (c == 0);
      req_valid  = 4'b0010;
      smp();
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL vfree_ready c%0d got %b exp 0010", c, req_ready); end
      checks++;
      if (vme_rd_busy !== (c >= 1 && c <= 5)) begin
        errors++; $display("FAIL vfree_busy c%0d got %b", c, vme_rd_busy);
      end
      checks++;
      if (vme_rd_done !== (c == 4)) begin errors++; $display("FAIL vfree_done c%0d got %b", c, vme_rd_done); end
      if (c == 2) begin
        checks++;
        if ({lut_pat1, lut_carry1, lut_pat0} !== {7'h6C, 12'hABC, pat_tab[1]}) begin
          errors++; $display("FAIL vfree_lane1 got %h/%h exp 6c/abc", lut_pat1, lut_carry1);
        end
      end
      if (c == 3) begin
        checks++;
        if ({lut_pat1, lut_carry1} !== '0) begin errors++; $display("FAIL vfree_lane1_idle got %h/%h exp 0/0", lut_pat1, lut_carry1); end
      end
      if (c == 4 || c == 6) begin
        checks++;
        if (vme_rd_data !== vexp) begin errors++; $display("FAIL vfree_data c%0d got %h exp %h", c, vme_rd_data, vexp); end
      end
      if (c == 4) begin
        checks++;
        if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL vfree_no_rsp got %b exp 0010", rsp_valid); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_starve();
    logic [3:0] e;
    int starved;
    starved = 0;
    do_reset();
    load_tab();
    vme_rd_pat   = 7'h3D;
    vme_rd_carry = 12'h5E1;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) cyc();
      vme_rd_req = (c == 0);
      req_valid  = (c <= 20) ? 4'hF : 4'h0;
      smp();
      if (c == 0) e = 4'b0011;
      else if (c <= 15) e = (c % 2 == 1) ? 4'b1100 : 4'b0011;
      else if (c == 16) e = 4'b0001;
      else if (c <= 20) e = (c % 2 == 1) ? 4'b0110 : 4'b1001;
      else e = 4'b0000;
      checks++;
      if (req_ready !== e) begin errors++; $display("FAIL starve_ready c%0d got %b exp %b", c, req_ready, e); end
      if (c >= 1 && c <= 16 && $countones(req_ready) == 2) starved++;
      checks++;
      if (vme_rd_busy !== (c >= 1 && c <= 20)) begin errors++; $display("FAIL starve_busy c%0d got %b", c, vme_rd_busy); end
      checks++;
      if (vme_rd_done !== (c == 19)) begin errors++; $display("FAIL starve_done c%0d got %b", c, vme_rd_done); end
      if (c == 17) begin
        checks++;
        if ({lut_pat1, lut_carry1, lut_pat0} !== {7'h3D, 12'h5E1, pat_tab[0]}) begin
          errors++; $display("FAIL starve_preempt got %h/%h/%h exp 3d/5e1/%h", lut_pat1, lut_carry1, lut_pat0, pat_tab[0]);
        end
      end
      if (c == 19) begin
        checks++;
        if (vme_rd_data !== lut_fn(7'h3D, 12'h5E1)) begin
          errors++; $display("FAIL starve_data got %h exp %h", vme_rd_data, lut_fn(7'h3D, 12'h5E1));
        end
        checks++;
        if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL starve_rsp got %b exp 0001", rsp_valid); end
      end
    end
    checks++;
    if (starved !== 15) begin errors++; $display("FAIL starve_count got %0d exp 15", starved); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    load_tab();
    vme_rd_pat   = 7'h44;
    vme_rd_carry = 12'h0F0;
    req_valid    = 4'hF;
    vme_rd_req   = 1'b1;
    smp();
    checks++;
    if (req_ready !== 4'b0011) begin errors++; $display("FAIL mid_grant got %b exp 0011", req_ready); end
    cyc();
    req_valid    = '0;
    vme_rd_req   = 1'b0;
    global_reset = 1'b1;
    smp();
    checks++;
    if ({lut_pat0, vme_rd_busy} !== {pat_tab[0], 1'b1}) begin
      errors++; $display("FAIL mid_inflight got %h/%b exp %h/1", lut_pat0, vme_rd_busy, pat_tab[0]);
    end
    cyc();
    global_reset = 1'b0;
    smp();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL mid_outputs got %h exp 0", outs); end
    for (int c = 3; c < 8; c++) begin
      cyc();
      req_valid = (c == 3) ? 4'hF : 4'h0;
      smp();
      if (c == 3) begin
        checks++;
        if (req_ready !== 4'b0011) begin errors++; $display("FAIL mid_ptr got %b exp 0011", req_ready); end
      end
      checks++;
      if (rsp_valid !== ((c == 6) ? 4'b0011 : 4'b0000)) begin
        errors++; $display("FAIL mid_rsp c%0d got %b", c, rsp_valid);
      end
      checks++;
      if ({vme_rd_busy, vme_rd_done} !== 2'b00) begin
        errors++; $display("FAIL mid_vme c%0d got %b%b exp 00", c, vme_rd_busy, vme_rd_done);
      end
    end
  endtask

  initial begin
    global_reset = 1'b1;
    req_valid    = '0;
    vme_rd_req   = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_vme_free();
    test_starve();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_lut_arbiter.md
Name: pattern_lut_arbiter

Overview:
- Shares the two read lanes of the ccLUT pattern lookup (lane 0: pat00/carry00, lane 1: pat01/carry01) among NREQ pattern-finder requesters and one VME debug readback port.
- Grants up to two lookups per cycle using round-robin order.
- Drives the LUT inputs from registers and tracks each lookup through the LUT latency. Returns offset, bend and quality to the requester that issued it.
- Sits between the pattern finder stages and the pattern_lut_ccLUT instance.

Parameters:
- NREQ, 4: number of functional requesters (2..8).
- MXPATB, 7: pattern word width, {hits[2:0], pid[3:0]}.
- MXPATC, 12: comparator-code (carry) width.
- LUT_LAT, 1: rising-edge cycles from LUT input register to valid LUT output.
- MAX_STARVE, 15: cycles a pending VME read may wait before it preempts lane 1.

Ports:
- clock  in  1  system clock, 40 MHz.
- global_reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester lookup request; held until accepted.
- req_ready  out  NREQ  grant; handshake completes when req_valid & req_ready.
- req_pat  in  NREQ*MXPATB  per-requester pattern word.
- req_carry  in  NREQ*MXPATC  per-requester carry address.
- lut_pat0, lut_pat1  out  MXPATB  registered LUT pattern inputs.
- lut_carry0, lut_carry1  out  MXPATC  registered LUT carry inputs.
- lut_offs0, lut_offs1  in  4  LUT offset outputs.
- lut_bend0, lut_bend1  in  5  LUT bend outputs.
- lut_quality0, lut_quality1  in  9  LUT quality outputs.
- rsp_valid  out  NREQ  one-cycle response strobe per requester.
- rsp_offs  out  NREQ*4  per-requester offset, held until the next response.
- rsp_bend  out  NREQ*5  per-requester bend.
- rsp_quality  out  NREQ*9  per-requester quality.
- vme_rd_req  in  1  readback start; sampled only in state IDLE.
- vme_rd_pat  in  MXPATB  readback pattern word.
- vme_rd_carry  in  MXPATC  readback carry address.
- vme_rd_busy  out  1  high in every state except IDLE.
- vme_rd_done  out  1  one-cycle pulse when vme_rd_data is updated.
- vme_rd_data  out  18  {offs, bend, quality}, held until the next readback.

Behaviour:
- Reset values: all outputs 0; round-robin pointer 0; starve counter 0; VME FSM in IDLE.
- Reset mid-operation discards all in-flight tags. No rsp_valid or vme_rd_done is issued for lookups granted before reset.
- req_ready is combinational from req_valid, the pointer and the VME preempt state. It is never high for a requester whose req_valid is low.
- Arbitration, cycle N:
  - Scan requesters starting at the pointer, wrapping at NREQ.
  - The first valid requester goes to lane 0, the second to lane 1.
  - If any grant occurs, the pointer at N+1 = (last granted index + 1) mod NREQ. Otherwise the pointer is unchanged.
- Lane registers: at N+1, lut_patX/lut_carryX hold the granted request. An idle lane holds pat=0 and carry=0; pid 0 reads blank.
- Tag pipeline: each lane carries {valid, owner[2:0], is_vme} through a delay line of length LUT_LAT. The LUT outputs for that lane are captured into the owner's rsp_* registers.
- Response timing: rsp_valid[owner] is high for one cycle at N+2+LUT_LAT (N+3 at default). Total grant-to-response latency is fixed at LUT_LAT+2.
- One requester may receive two responses in consecutive cycles. Both lanes never target the same requester in the same cycle, because one requester gets at most one grant per cycle.
- VME FSM:
  - IDLE: on vme_rd_req, latch vme_rd_pat/vme_rd_carry, clear the starve counter, go to WAIT_SLOT.
  - WAIT_SLOT: take lane 1 in any cycle with at most one functional grant, or when starve counter == MAX_STARVE. In the preempt case, functional arbitration is limited to lane 0 only. On taking lane 1, go to WAIT_DATA. Otherwise increment the starve counter, saturating at MAX_STARVE.
  - WAIT_DATA: when the VME tag emerges, load vme_rd_data, pulse vme_rd_done, go to DONE.
  - DONE: one cycle, then IDLE. vme_rd_req is ignored in DONE.
- A VME lookup never produces an rsp_valid. A functional lookup never updates vme_rd_data.
- At most one VME lookup is outstanding.

Test Plan:
- Single request: req_valid=4'b0001, pat=7'h5A (pid A, hits 5), carry=12'h123, LUT model returns offs=3, bend=9, quality=0x1F0 → req_ready[0] at cycle 0; lut_pat0=7'h5A and lut_carry0=12'h123 at cycle 1; rsp_valid[0] pulse at cycle 3 with those values; lane 1 holds zeros.
- Full contention: req_valid=4'b1111 held for 4 cycles → grants {0,1}, {2,3}, {0,1}, {2,3}; pointer sequence 0, 2, 0, 2; 8 responses in grant order.
- Wrap: pointer=3, req_valid=4'b1001 → requester 3 on lane 0, requester 0 on lane 1; pointer becomes 1.
- VME free slot: vme_rd_req with only req_valid[1] active → VME on lane 1 in the first WAIT_SLOT cycle; vme_rd_done 3 cycles later with the correct 18-bit word; busy high for 5 cycles total.
- VME starvation: all requesters valid continuously, vme_rd_req pulsed → exactly 15 starved cycles, then lane 1 preempted for one cycle with one functional grant; vme_rd_done follows LUT_LAT+2 later.
- Reset mid-flight: assert global_reset in the cycle after a 2-lane grant → no rsp_valid afterwards; all outputs 0; pointer 0; FSM in IDLE.
